// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_op;
  logic [5:0]  out_funct;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_imm;
  logic [4:0]  out_dst;
  logic        out_reg_we;
  logic        out_mem_rd;
  logic        out_mem_wr;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_funct, out_a, out_b,
           out_imm, out_dst, out_reg_we, out_mem_rd, out_mem_wr
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_funct, out_a, out_b,
           out_imm, out_dst, out_reg_we, out_mem_rd, out_mem_wr
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-style decode stage: field decode, 32-bit register scoreboard, one-entry output register.
// Optional writeback bypass of source operands when DECODE_WB_BYPASS_EN is defined.
module decode_stage (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus,
  output logic [4:0]    rf_rs,
  output logic [4:0]    rf_rt,
  input  logic [31:0]   rf_rd1,
  input  logic [31:0]   rf_rd2,
  input  logic          wb_we,
  input  logic [4:0]    wb_rd,
  input  logic [31:0]   wb_wd
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [4:0]  dst;
  logic        we_raw, we, use_rs, use_rt, mem_rd, mem_wr;
  logic [31:0] imm;
  logic        byp_rs, byp_rt;
  logic        hz, in_ready_c, accept;
  logic [31:0] opa, opb;
  logic [31:0] sb, sb_next;

  assign op    = bus.in_instr[31:26];
  assign rs    = bus.in_instr[25:21];
  assign rt    = bus.in_instr[20:16];
  assign rd    = bus.in_instr[15:11];
  assign rf_rs = rs;
  assign rf_rt = rt;

  always_comb begin
    dst    = '0;
    we_raw = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    imm    = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
    case (op)
      OP_RTYPE: begin
        dst = rd; we_raw = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        dst = rt; we_raw = 1'b1; use_rs = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dst = rt; we_raw = 1'b1; use_rs = 1'b1;
        imm = {16'h0000, bus.in_instr[15:0]};
      end
      OP_LUI: begin
        dst = rt; we_raw = 1'b1;
        imm = {bus.in_instr[15:0], 16'h0000};
      end
      OP_LW: begin
        dst = rt; we_raw = 1'b1; mem_rd = 1'b1; use_rs = 1'b1;
      end
      OP_SW: begin
        mem_wr = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        use_rs = 1'b1; use_rt = 1'b1;
      end
      default: ;
    endcase
    we = we_raw && (dst != 5'd0);
  end

  always_comb begin
    byp_rs = 1'b0;
    byp_rt = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    byp_rs = wb_we && (wb_rd != 5'd0) && (wb_rd == rs);
    byp_rt = wb_we && (wb_rd != 5'd0) && (wb_rd == rt);
`endif
  end

  // sb[0] is never set, so register 0 can never raise a hazard.
  assign hz = (use_rs && sb[rs] && !byp_rs) ||
              (use_rt && sb[rt] && !byp_rt) ||
              (we && sb[dst]);

  assign in_ready_c   = !bus.flush && !hz && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = in_ready_c;
  assign accept       = bus.in_valid && in_ready_c;

  assign opa = (rs == 5'd0) ? '0 : (byp_rs ? wb_wd : rf_rd1);
  assign opb = (rt == 5'd0) ? '0 : (byp_rt ? wb_wd : rf_rd2);

  // Set is applied after the clears so a same-cycle set on the cleared bit wins.
  always_comb begin
    sb_next = sb;
    if (wb_we)
      sb_next[wb_rd] = 1'b0;
    if (bus.flush && bus.out_valid && bus.out_reg_we)
      sb_next[bus.out_dst] = 1'b0;
    if (accept && we)
      sb_next[dst] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb             <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_pc     <= '0;
      bus.out_op     <= '0;
      bus.out_funct  <= '0;
      bus.out_a      <= '0;
      bus.out_b      <= '0;
      bus.out_imm    <= '0;
      bus.out_dst    <= '0;
      bus.out_reg_we <= 1'b0;
      bus.out_mem_rd <= 1'b0;
      bus.out_mem_wr <= 1'b0;
    end else begin
      sb <= sb_next;
      if (accept) begin
        bus.out_valid  <= 1'b1;
        bus.out_pc     <= bus.in_pc;
        bus.out_op     <= op;
        bus.out_funct  <= bus.in_instr[5:0];
        bus.out_a      <= opa;
        bus.out_b      <= opb;
        bus.out_imm    <= imm;
        bus.out_dst    <= dst;
        bus.out_reg_we <= we;
        bus.out_mem_rd <= mem_rd;
        bus.out_mem_wr <= mem_wr;
      end else if (bus.flush || bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table plus stall, backpressure, flush and reset sequences.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rf_rs, rf_rt;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic [31:0] regs [32];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .rf_rs (rf_rs),
    .rf_rt (rf_rt),
    .rf_rd1(rf_rd1),
    .rf_rd2(rf_rd2),
    .wb_we (wb_we),
    .wb_rd (wb_rd),
    .wb_wd (wb_wd)
  );

  function automatic logic [31:0] f(input int n);
    return 32'hC0DE_0000 + n;
  endfunction

  // Register file model: r0 holds garbage that the stage must never forward.
  assign rf_rd1 = regs[rf_rs];
  assign rf_rd2 = regs[rf_rt];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= f(i);
      regs[0] <= 32'hDEAD_BEEF;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_wd;
    end
  end

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeback(input int r, input logic [31:0] d);
    wb_we = 1'b1;
    wb_rd = 5'(r);
    wb_wd = d;
    tick();
    wb_we = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic        we;
    logic        mrd;
    logic        mwr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;

    vecs[0]  = '{itype(6'h08, 0, 3, 16'hFFFF),   32'h0,  f(3),  32'hFFFF_FFFF, 5'd3,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{itype(6'h0D, 0, 2, 16'h8000),   32'h0,  f(2),  32'h0000_8000, 5'd2,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{itype(6'h0F, 0, 2, 16'h1234),   32'h0,  f(2),  32'h1234_0000, 5'd2,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{rtype(1, 1, 0, 6'h20),          f(1),   f(1),  32'h0000_0020, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{itype(6'h23, 9, 7, 16'hFFFC),   f(9),   f(7),  32'hFFFF_FFFC, 5'd7,  1'b1, 1'b1, 1'b0};
    vecs[5]  = '{itype(6'h2B, 11, 10, 16'h0010), f(11),  f(10), 32'h0000_0010, 5'd0,  1'b0, 1'b0, 1'b1};
    vecs[6]  = '{itype(6'h0C, 13, 12, 16'hF0F0), f(13),  f(12), 32'h0000_F0F0, 5'd12, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{itype(6'h0A, 15, 14, 16'h8001), f(15),  f(14), 32'hFFFF_8001, 5'd14, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{itype(6'h04, 1, 2, 16'h0003),   f(1),   f(2),  32'h0000_0003, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{itype(6'h3F, 3, 4, 16'h0000),   f(3),   f(4),  32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{rtype(17, 18, 16, 6'h22),       f(17),  f(18), 32'hFFFF_8022, 5'd16, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{itype(6'h09, 21, 20, 16'h7FFF), f(21),  f(20), 32'h0000_7FFF, 5'd20, 1'b1, 1'b0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    wb_we         = 1'b0;
    wb_rd         = '0;
    wb_wd         = '0;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_imm", bus.out_imm, 32'h0);
    chk("rst_out_a", bus.out_a, 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;

    // Decode table: one instruction at a time, destination retired right after.
    for (int i = 0; i < 12; i++) begin
      pc = 32'h0040_0000 + 32'(i * 4);
      bus.in_valid = 1'b1;
      bus.in_instr = vecs[i].instr;
      bus.in_pc    = pc;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_pc", i), bus.out_pc, pc);
      chk($sformatf("v%0d_op", i), 32'(bus.out_op), 32'(vecs[i].instr[31:26]));
      chk($sformatf("v%0d_funct", i), 32'(bus.out_funct), 32'(vecs[i].instr[5:0]));
      chk($sformatf("v%0d_a", i), bus.out_a, vecs[i].a);
      chk($sformatf("v%0d_b", i), bus.out_b, vecs[i].b);
      chk($sformatf("v%0d_imm", i), bus.out_imm, vecs[i].imm);
      chk($sformatf("v%0d_dst", i), 32'(bus.out_dst), 32'(vecs[i].dst));
      chk($sformatf("v%0d_we", i), 32'(bus.out_reg_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_mrd", i), 32'(bus.out_mem_rd), 32'(vecs[i].mrd));
      chk($sformatf("v%0d_mwr", i), 32'(bus.out_mem_wr), 32'(vecs[i].mwr));
      if (vecs[i].we) writeback(int'(vecs[i].dst), regs[vecs[i].dst]);
      else tick();
    end

    // RAW: add r6,r5,r1 behind addi r5.
    bus.in_valid = 1'b1;
    bus.in_instr = itype(6'h08, 1, 5, 16'h0007);
    bus.in_pc    = 32'h0000_1000;
    @(negedge clk);
    chk("raw_first_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_instr = rtype(5, 1, 6, 6'h20);
    bus.in_pc    = 32'h0000_1004;
    @(negedge clk);
    chk("raw_stall0", 32'(bus.in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("raw_stall1", 32'(bus.in_ready), 32'd0);
    tick();
    wb_we = 1'b1;
    wb_rd = 5'd5;
    wb_wd = 32'h5555_0005;
`ifdef DECODE_WB_BYPASS_EN
    @(negedge clk);
    chk("raw_wb_cycle_ready", 32'(bus.in_ready), 32'd1);
    tick();
    wb_we = 1'b0;
`else
    @(negedge clk);
    chk("raw_wb_cycle_ready", 32'(bus.in_ready), 32'd0);
    tick();
    wb_we = 1'b0;
    @(negedge clk);
    chk("raw_after_wb_ready", 32'(bus.in_ready), 32'd1);
    tick();
`endif
    bus.in_valid = 1'b0;
    chk("raw_valid", 32'(bus.out_valid), 32'd1);
    chk("raw_pc", bus.out_pc, 32'h0000_1004);
    chk("raw_a", bus.out_a, 32'h5555_0005);
    chk("raw_b", bus.out_b, f(1));
    chk("raw_dst", 32'(bus.out_dst), 32'd6);
    writeback(6, regs[6]);

    // Backpressure: held entry stays stable for three cycles.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = itype(6'h0D, 0, 22, 16'h0001);
    bus.in_pc     = 32'h0000_2000;
    @(negedge clk);
    chk("bp_first_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_instr = itype(6'h0C, 1, 23, 16'h00FF);
    bus.in_pc    = 32'h0000_2004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_pc", k), bus.out_pc, 32'h0000_2000);
      chk($sformatf("bp%0d_imm", k), bus.out_imm, 32'h0000_0001);
      chk($sformatf("bp%0d_dst", k), 32'(bus.out_dst), 32'd22);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_pc", bus.out_pc, 32'h0000_2004);
    chk("bp_next_imm", bus.out_imm, 32'h0000_00FF);
    chk("bp_next_dst", 32'(bus.out_dst), 32'd23);
    writeback(22, regs[22]);
    writeback(23, regs[23]);

    // Flush of a held lw r7; dependent add must then go through without stall.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = itype(6'h23, 1, 7, 16'h0000);
    bus.in_pc     = 32'h0000_3000;
    tick();
    chk("fl_held_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_held_mrd", 32'(bus.out_mem_rd), 32'd1);
    bus.flush    = 1'b1;
    bus.in_instr = rtype(7, 7, 8, 6'h20);
    bus.in_pc    = 32'h0000_3004;
    @(negedge clk);
    chk("fl_cycle_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    chk("fl_valid_cleared", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fl_no_stall_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("fl_next_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_next_dst", 32'(bus.out_dst), 32'd8);
    chk("fl_next_a", bus.out_a, f(7));
    writeback(8, regs[8]);

    // WAW stall on r4, then asynchronous reset in the middle of it.
    bus.in_valid = 1'b1;
    bus.in_instr = itype(6'h08, 1, 4, 16'h0001);
    bus.in_pc    = 32'h0000_4000;
    tick();
    bus.in_instr = itype(6'h23, 2, 4, 16'h0000);
    bus.in_pc    = 32'h0000_4004;
    @(negedge clk);
    chk("waw_stall_ready", 32'(bus.in_ready), 32'd0);
    chk("waw_held_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_dst", 32'(bus.out_dst), 32'd0);
    chk("mid_rst_imm", bus.out_imm, 32'h0);
    chk("mid_rst_sb_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_dst", 32'(bus.out_dst), 32'd4);
    chk("post_rst_mrd", 32'(bus.out_mem_rd), 32'd1);
    writeback(4, regs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
